// File: rtl/mem_access_unit.sv
// Load/store access unit: one request at a time, full-word memory accesses,
// read-modify-write for sb/sh, sign/zero-extended load data, error reporting.
module mem_access_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_write_en,
    output logic [WORD_SIZE-1:0] mem_write_data,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [2:0]           dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready stays low until the response pulse ends.
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    state_t         state;
    logic [2:0]     funct3_q;
    logic [15:0]    wdata_q;
    logic           we_q;
    logic           req_bad;
    logic [WORD_SIZE-1:0] load_ext;
    logic [WORD_SIZE-1:0] merged;

    assign dbg_state    = state;
    assign mem_write_en = we_q & ~rst;

    // Illegal funct3 for the direction, or misaligned half/word access.
    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            3'b000:  req_bad = 1'b0;
            3'b001:  req_bad = req_addr[0];
            3'b010:  req_bad = |req_addr[1:0];
            3'b100:  req_bad = req_write;
            3'b101:  req_bad = req_write | req_addr[0];
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        load_ext = mem_data;
        case (funct3_q)
            3'b000:  load_ext = {{(WORD_SIZE-8){mem_data[7]}}, mem_data[7:0]};
            3'b001:  load_ext = {{(WORD_SIZE-16){mem_data[15]}}, mem_data[15:0]};
            3'b100:  load_ext = {{(WORD_SIZE-8){1'b0}}, mem_data[7:0]};
            3'b101:  load_ext = {{(WORD_SIZE-16){1'b0}}, mem_data[15:0]};
            default: load_ext = mem_data;
        endcase
    end

    assign merged = funct3_q[0] ? {mem_data[WORD_SIZE-1:16], wdata_q[15:0]}
                                : {mem_data[WORD_SIZE-1:8], wdata_q[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            we_q           <= 1'b0;
            funct3_q       <= 3'b000;
            wdata_q        <= 16'h0000;
        end else begin
            resp_valid <= 1'b0;
            we_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= req_addr;
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            state          <= WRITE;
                            we_q           <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state <= MERGE;
                        end
                    end
                end
                LOAD: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_ext;
                end
                MERGE: begin
                    state          <= WRITE;
                    we_q           <= 1'b1;
                    mem_write_data <= merged;
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit sitting between the CPU datapath and the combined instruction/data memory. It accepts one load or store request at a time and issues the byte-addressed, full-word memory accesses. Sub-word stores are built as read-modify-write sequences because the memory only writes whole 32-bit words. It returns sign- or zero-extended load data and flags misaligned or illegal requests without touching memory.

## Interface

- WORD_SIZE, 32, data/address width; only 32 is supported.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; sampled only when req_ready=1.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_addr  in  WORD_SIZE  byte address.
- req_wdata  in  WORD_SIZE  store data; low byte/half used for sb/sh.
- resp_valid  out  1  one-cycle pulse marking request completion.
- resp_rdata  out  WORD_SIZE  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid.
- mem_addr  out  WORD_SIZE  byte address to memory.
- mem_write_en  out  1  memory word write strobe.
- mem_write_data  out  WORD_SIZE  word to write; bits [7:0] go to mem_addr.
- mem_data  in  WORD_SIZE  asynchronous read data; bits [7:0] hold the byte at mem_addr.

## Operation

- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch write, funct3, addr and wdata.
  - Request is an error if funct3 is illegal for its direction, if lh/lhu/sh has addr[0]=1, or if lw/sw has addr[1:0]≠00. Error → RESP with err set; no memory access.
  - Load → LOAD.
  - sw → WRITE, with write data = wdata.
  - sb/sh → MERGE.
- LOAD: mem_addr=latched addr; capture the extended load data → RESP.
  - lb: sign-extend mem_data[7:0].
  - lbu: zero-extend mem_data[7:0].
  - lh: sign-extend mem_data[15:0].
  - lhu: zero-extend mem_data[15:0].
  - lw: mem_data unchanged.
- MERGE: mem_addr=latched addr; capture the merged word → WRITE.
  - sb: {mem_data[31:8], wdata[7:0]}.
  - sh: {mem_data[31:16], wdata[15:0]}.
- WRITE: mem_write_en=1, mem_addr=latched addr, mem_write_data=merged/store word → RESP.
- RESP: resp_valid=1, req_ready=0 → IDLE.
- resp_rdata and resp_err update only on entry to RESP and hold until the next response.
- Address handling:
  - Addresses pass to memory unmodified; no alignment masking.
  - Wrap at the memory's top address is the memory's concern.
  - The error check applies regardless of what the memory can tolerate.
- mem_addr is a register: loaded on request accept, otherwise held.
- mem_write_en is high only in WRITE and is gated low whenever rst=1.

## Timing

- Request accepted at edge T, when req_valid and req_ready are both 1. The accepted request is the cycle before T+1.
- resp_valid is high during the cycle after edge:
  - T+1 for an error;
  - T+2 for loads and sw;
  - T+3 for sb/sh.
- Next accept is earliest in the cycle following the resp_valid cycle; there is no back-to-back overlap.
- Load data is sampled from mem_data combinationally in the LOAD cycle. The memory read is asynchronous, so no extra wait state is needed.
- In the MERGE cycle, mem_data reflects the pre-store word; the write occurs at the edge ending WRITE.
- Reset values (after any rst edge):
  - state=IDLE, req_ready=1, resp_valid=0, resp_err=0;
  - resp_rdata=0, mem_addr=0, mem_write_data=0, mem_write_en=0.
- Reset mid-operation: the request is abandoned, no response is generated, and no write is issued at or after the reset cycle.
- req_valid while not ready is ignored; the requester must hold the request until it sees req_ready.

## Test plan

- Reset, then lw at addr 0 with memory word 0x01500093 → resp_valid at T+2, resp_rdata=0x01500093, resp_err=0, mem_write_en never high.
- sw 0x00000015 to addr 24, then lw from 24 → one mem_write_en pulse at T+1 with mem_addr=24 and mem_write_data=0x15; the load returns 0x00000015.
- Memory word at 24 = 0xAABBCCDD; sb 0x11 to 24 → MERGE then WRITE with mem_write_data=0xAABBCC11; lbu 24 → 0x11, lb 27 → 0xFFFFFFAA, lhu 26 → 0x0000AABB.
- sh 0x8001 to addr 24 (word 0x12345678) → writes 0x12348001; lh 24 → 0xFFFF8001.
- Misaligned lw at 0x1A, sh at 0x19, and load funct3=011 → resp_err=1 at T+1, resp_rdata=0, no mem_write_en, memory unchanged.
- Assert rst during the MERGE cycle of an sb → no mem_write_en, no resp_valid; req_ready=1 after the reset edge; the target word is unchanged.
